run_sequencer: RTL

- Synthesizable launch/monitor controller that drives a processor core's Start/Ack handshake over several programs in sequence.
- Replaces the hand-scripted single-run Start pulse and Ack wait.
- Sits between a host/self-test trigger and the core. It selects each program, pulses Start, measures the cycles to Ack, applies a watchdog timeout, and reports per-run results and a failure mask.

---
 rtl/run_sequencer.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/run_sequencer.sv
// Launch/monitor controller: runs NUM_PROGS programs back-to-back on a core via a
// Start/Ack handshake, timing each run and flagging watchdog timeouts.
module run_sequencer #(
  parameter int unsigned NUM_PROGS = 3,
  parameter int unsigned CYC_W     = 16,
  parameter int unsigned TIMEOUT   = 10000,
  parameter int unsigned PSEL_W    = (NUM_PROGS > 1) ? $clog2(NUM_PROGS) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 go,
  input  logic                 abort,
  input  logic                 ack,
  output logic                 start,
  output logic [PSEL_W-1:0]    prog_sel,
  output logic                 busy,
  output logic                 done,
  output logic                 run_valid,
  output logic [PSEL_W-1:0]    run_idx,
  output logic [CYC_W-1:0]     run_cycles,
  output logic                 run_fail,
  output logic [NUM_PROGS-1:0] fail_mask,
  output logic                 aborted
);

  typedef enum logic [2:0] {
    StIdle,
    StLaunch,
    StWait,
    StReport,
    StDrain,
    StDone
  } state_e;

  localparam logic [CYC_W-1:0]  TimeoutVal = CYC_W'(TIMEOUT);
  localparam logic [PSEL_W-1:0] LastProg   = PSEL_W'(NUM_PROGS - 1);

  state_e                 state_q, state_d;
  logic [PSEL_W-1:0]      prog_sel_q, prog_sel_d;
  logic [PSEL_W-1:0]      run_idx_q, run_idx_d;
  logic [CYC_W-1:0]       cnt_q, cnt_d, cnt_inc;
  logic [CYC_W-1:0]       run_cycles_q, run_cycles_d;
  logic                   run_fail_q, run_fail_d;
  logic [NUM_PROGS-1:0]   fail_mask_q, fail_mask_d;
  logic                   aborted_q, aborted_d;
  logic                   active;

  assign cnt_inc = cnt_q + CYC_W'(1);
  assign active  = (state_q != StIdle) && (state_q != StDone);

  always_comb begin
    state_d      = state_q;
    prog_sel_d   = prog_sel_q;
    run_idx_d    = run_idx_q;
    cnt_d        = cnt_q;
    run_cycles_d = run_cycles_q;
    run_fail_d   = run_fail_q;
    fail_mask_d  = fail_mask_q;
    aborted_d    = aborted_q;

    unique case (state_q)
      StIdle, StDone: begin
        if (go) begin
          state_d      = StLaunch;
          prog_sel_d   = '0;
          fail_mask_d  = '0;
          aborted_d    = 1'b0;
          run_idx_d    = '0;
          run_cycles_d = '0;
          run_fail_d   = 1'b0;
        end
      end
      StLaunch: begin
        cnt_d   = '0;
        state_d = StWait;
      end
      StWait: begin
        cnt_d = cnt_inc;
        // Ack on the timeout cycle still counts as success.
        if (ack) begin
          state_d      = StReport;
          run_idx_d    = prog_sel_q;
          run_cycles_d = cnt_inc;
          run_fail_d   = 1'b0;
        end else if (cnt_inc == TimeoutVal) begin
          state_d                 = StReport;
          run_idx_d               = prog_sel_q;
          run_cycles_d            = TimeoutVal;
          run_fail_d              = 1'b1;
          fail_mask_d[prog_sel_q] = 1'b1;
        end
      end
      StReport: begin
        state_d = StDrain;
      end
      StDrain: begin
        if (!ack) begin
          if (prog_sel_q == LastProg) begin
            state_d = StDone;
          end else begin
            prog_sel_d = prog_sel_q + PSEL_W'(1);
            state_d    = StLaunch;
          end
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Abort overrides everything, including a coincident Ack or timeout.
    if (abort && active) begin
      state_d      = StDone;
      aborted_d    = 1'b1;
      prog_sel_d   = prog_sel_q;
      run_idx_d    = run_idx_q;
      cnt_d        = cnt_q;
      run_cycles_d = run_cycles_q;
      run_fail_d   = run_fail_q;
      fail_mask_d  = fail_mask_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      prog_sel_q   <= '0;
      run_idx_q    <= '0;
      cnt_q        <= '0;
      run_cycles_q <= '0;
      run_fail_q   <= 1'b0;
      fail_mask_q  <= '0;
      aborted_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      prog_sel_q   <= prog_sel_d;
      run_idx_q    <= run_idx_d;
      cnt_q        <= cnt_d;
      run_cycles_q <= run_cycles_d;
      run_fail_q   <= run_fail_d;
      fail_mask_q  <= fail_mask_d;
      aborted_q    <= aborted_d;
    end
  end

  // Start is suppressed in the same cycle Abort is seen so no launch follows an abort.
  assign start      = (state_q == StLaunch) && !abort;
  assign busy       = active;
  assign done       = (state_q == StDone);
  assign run_valid  = (state_q == StReport);
  assign prog_sel   = prog_sel_q;
  assign run_idx    = run_idx_q;
  assign run_cycles = run_cycles_q;
  assign run_fail   = run_fail_q;
  assign fail_mask  = fail_mask_q;
  assign aborted    = aborted_q;

endmodule
